// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end sharing one binary (Stein) GCD engine.
// Optional macro GCD_ARB_CYCLE_COUNT_EN adds the rsp_cycles latency output.
module gcd_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_u,
    input  logic [N*W-1:0] req_v,
    output logic [N-1:0]   req_ready,
    output logic           rsp_valid,
    output logic [W-1:0]   rsp_gcd,
    output logic [IDW-1:0] rsp_id,
    input  logic           rsp_ready,
`ifdef GCD_ARB_CYCLE_COUNT_EN
    output logic           busy,
    output logic [7:0]     rsp_cycles
`else
    output logic           busy
`endif
);

    localparam int KW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REDUCE,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [W-1:0]   r_res;
    logic [KW-1:0]  r_k;

    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_gidx;
    logic           w_found;
    int             w_j;
    logic           w_accept;
    logic [W-1:0]   w_u;
    logic [W-1:0]   w_v;
    logic           w_zero;
    logic           w_even2;
    logic           w_hit;
    logic [W-1:0]   w_rx;
    logic [W-1:0]   w_ry;

    // Round-robin scan from r_rr_ptr; grant only while idle and out of reset
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_j     = 0;
        if (rst_n && r_state == IDLE) begin
            for (int i = 0; i < N; i++) begin
                w_j = int'(r_rr_ptr) + i;
                if (w_j >= N) w_j = w_j - N;
                if (!w_found && req_valid[IDW'(w_j)]) begin
                    w_grant[IDW'(w_j)] = 1'b1;
                    w_gidx             = IDW'(w_j);
                    w_found            = 1'b1;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;
    assign w_u       = req_u[w_gidx*W +: W];
    assign w_v       = req_v[w_gidx*W +: W];
    assign w_zero    = (w_u == '0) || (w_v == '0);
    assign w_even2   = !r_x[0] && !r_y[0];

    // One Stein reduction step on the current x/y pair
    always_comb begin
        w_rx  = r_x;
        w_ry  = r_y;
        w_hit = 1'b0;
        if (!r_x[0]) begin
            w_rx = r_x >> 1;
        end else if (!r_y[0]) begin
            w_ry = r_y >> 1;
        end else if (r_x == r_y) begin
            w_hit = 1'b1;
        end else if (r_x > r_y) begin
            w_rx = (r_x - r_y) >> 1;
        end else begin
            w_ry = (r_y - r_x) >> 1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Next state; leaving SHIFT folds in the first reduce step,
    // so gcd(1,1) responds two cycles after accept
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nx = w_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                if (!w_even2) w_state_nx = w_hit ? DONE : REDUCE;
            end
            REDUCE: begin
                if (w_hit) w_state_nx = DONE;
            end
            DONE: begin
                if (rsp_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Operand capture, engine datapath and result/owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_k      <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x  <= w_u;
                        r_y  <= w_v;
                        r_k  <= '0;
                        r_id <= w_gidx;
                        r_rr_ptr <= (w_gidx == IDW'(N - 1)) ?
                                    '0 : w_gidx + 1'b1;
                        if (w_zero) r_res <= w_u | w_v;
                    end
                end
                SHIFT: begin
                    if (w_even2) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_x <= w_rx;
                        r_y <= w_ry;
                        if (w_hit) r_res <= r_x << r_k;
                    end
                end
                REDUCE: begin
                    r_x <= w_rx;
                    r_y <= w_ry;
                    if (w_hit) r_res <= r_x << r_k;
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_ARB_CYCLE_COUNT_EN
    logic [7:0] r_cyc;

    // Clocks from accept (counted as 1) to DONE entry, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
        end else if (w_accept) begin
            r_cyc <= 8'd1;
        end else if ((r_state == SHIFT || r_state == REDUCE)
                     && r_cyc != 8'hFF) begin
            r_cyc <= r_cyc + 8'd1;
        end
    end

    assign rsp_cycles = r_cyc;
`endif

    assign rsp_valid = (r_state == DONE);
    assign rsp_gcd   = r_res;
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);

endmodule
